core_if: RTL and testbench
==========================

# core_IF

Instruction-fetch stage of the 0dMIPS five-stage pipeline. It owns the program counter, issues in-order requests to instruction memory over a ready/valid handshake, buffers returned words in a small FIFO, and registers one instruction per cycle into `IF_regs` for the decode stage. It honours the hazard-unit stall and redirect requests (taken branch, jump, exception, ERET), discarding any in-flight responses from the squashed path.

## Interface
Parameters:
- `RESET_PC`, 64'h0, first fetch address after reset
- `FIFO_DEPTH`, 2, fetch-buffer entries and maximum outstanding requests; power of two, ≥2

Ports:
- `clock`  in  1  stage clock
- `reset`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold `IF_regs`; no FIFO pop
- `redirect`  in  1  squash and restart fetch at `redirect_pc`
- `redirect_pc`  in  64  new fetch address, word aligned
- `imem_req`  out  1  request valid
- `imem_addr`  out  64  request address
- `imem_ready`  in  1  memory accepts request
- `imem_rvalid`  in  1  response valid; in order, ≥1 cycle after acceptance
- `imem_rdata`  in  32  response instruction word
- `IF_regs`  out  `IF_regs_t`  {inst, pc, pc4} to decode
- `fetch_count`, `squash_count`  out  32 each  (only with `IF_PERF_COUNTERS_EN`)

## Operation
- Registers: `fetch_pc`, `resp_pc`, `outstanding` (0..FIFO_DEPTH), `drop_cnt`, FIFO of {pc, inst}, state.
- States: `BOOT` (first cycle out of reset, no request) -> `FETCH`. `FETCH` -> `DRAIN` on `redirect` with non-zero outstanding-after-this-cycle; `FETCH` stays on `redirect` otherwise. `DRAIN` -> `FETCH` when `drop_cnt` reaches 0 (including the cycle its last response arrives). `redirect` in `DRAIN` reloads PCs and keeps the drop count.
- Request: `imem_req` = state==`FETCH` && !`redirect` && (`outstanding` + FIFO occupancy) < `FIFO_DEPTH`. `imem_addr` = `fetch_pc`. On accept (`imem_req && imem_ready`): `fetch_pc` += 4, `outstanding` += 1.
- Response: `outstanding` -= 1. If `drop_cnt` > 0: discard, `drop_cnt` -= 1. Else push {`resp_pc`, `imem_rdata`}, `resp_pc` += 4.
- Redirect: `fetch_pc` and `resp_pc` <= `redirect_pc`; FIFO cleared; `drop_cnt` <= outstanding remaining after this cycle's response (same-cycle response is itself dropped).
- `IF_regs` update priority: redirect -> '0; else stall -> hold; else FIFO non-empty -> pop, load {inst, pc, pc+4}; else '0 (bubble; inst 0 decodes as nop).
- PC arithmetic is 64-bit modulo; wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 is silent.
- Credit rule guarantees no push into a full FIFO; response with `outstanding`==0 is a protocol error (assertion), ignored.

## Timing
- Reset (async assert): `IF_regs`='0, `imem_req`=0, `imem_addr`=`RESET_PC`, `fetch_pc`=`resp_pc`=`RESET_PC`, counters 0, FIFO empty, state `BOOT`.
- First request cycle 1 after reset release.
- Latency: accept at N, earliest `rvalid` N+1, FIFO entry end of N+1, `IF_regs` valid end of N+2.
- Sustained 1 instruction/cycle with 1-cycle memory and `FIFO_DEPTH`≥2.
- Redirect at cycle R: `IF_regs`='0 end of R; first new request at R+1 if nothing to drain, else the cycle after the last dropped response.
- Reset mid-operation discards everything; memory must be reset concurrently.

## Configuration
- `IF_PERF_COUNTERS_EN`: defined -> `fetch_count` increments per instruction loaded into `IF_regs`, `squash_count` per dropped response plus per FIFO entry flushed; both saturate at 32'hFFFF_FFFF. Undefined -> ports and logic absent.

## Structure
- `IF_regs_t` already in `structures`; add `fetch_state_t` (`BOOT`, `FETCH`, `DRAIN`) there.
- One sub-module: `fetch_fifo` (parameterised depth, push/pop/clear, count output, async active-low reset).

## Test plan
- Reset release, 1-cycle memory returning addr-derived words -> `IF_regs.pc` 0,4,8,… from cycle 3, one per cycle, `pc4`=pc+4.
- `stall` held 3 cycles with FIFO full -> `IF_regs` frozen, `imem_req`=0, no loss; resumes at next pc.
- `redirect` to 64'h400 with 2 outstanding -> both responses dropped, state `DRAIN`, next `IF_regs.pc`=64'h400, never stale words.
- `redirect` coincident with `imem_rvalid` and `stall` -> response dropped, `IF_regs`='0 (redirect wins).
- Random `imem_ready` and 1–4-cycle response latency, 1000 instructions -> sequential pcs, `outstanding` ≤ `FIFO_DEPTH`.
- `RESET_PC`=64'hFFFF_FFFF_FFFF_FFF8 -> pcs …FFF8, …FFFC, 0, 4.

Source files
------------

// File: rtl/core_if_pkg.sv
// Shared pipeline structures used by the instruction-fetch stage (package `structures`).
package structures;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] pc4;
    } IF_regs_t;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/core_if_fetch_fifo.sv
// Fetch buffer: power-of-two FIFO with push/pop/clear and an occupancy count.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 96
) (
    input  logic                           clock_i,
    input  logic                           reset_ni,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic                           clear_i,
    input  logic [W-1:0]                   wdata_i,
    output logic [W-1:0]                   rdata_o,
    output logic [$clog2(DEPTH):0]         count_o,
    output logic                           empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q + CW'(push_i) - CW'(pop_i);
    end

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/core_if.sv
// Instruction-fetch stage: owns the PC, issues credit-limited imem requests, buffers words, feeds IF_regs.
// Optional macro IF_PERF_COUNTERS_EN adds saturating fetch_count / squash_count outputs.
module core_if
    import structures::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         stall,
    input  logic         redirect,
    input  logic [63:0]  redirect_pc,
    // imem: a request transfers when imem_req && imem_ready in the same cycle; imem_req never
    // depends on imem_ready. Responses return in order, one per imem_rvalid cycle, no back-pressure.
    output logic         imem_req,
    output logic [63:0]  imem_addr,
    input  logic         imem_ready,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output IF_regs_t     IF_regs,
`ifdef IF_PERF_COUNTERS_EN
    output logic [31:0]  fetch_count,
    output logic [31:0]  squash_count,
`endif
    output fetch_state_t state_dbg
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state_q;
    logic [63:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, out_after, drop_q, drop_d, fifo_count;
    logic [CW:0]   credit_used;
    IF_regs_t      if_regs_q;
    logic          accept, resp, fifo_push, fifo_pop, fifo_empty;
    fetch_entry_t  fifo_head, fifo_wdata;

    // A pop this cycle frees a slot, which is what lets a 1-cycle memory sustain one word per cycle.
    always_comb begin
        fifo_pop    = !redirect && !stall && !fifo_empty;
        credit_used = (CW+1)'(outstanding_q) + (CW+1)'(fifo_count) - (CW+1)'(fifo_pop);
        imem_req    = (state_q == FETCH) && !redirect && (credit_used < (CW+1)'(FIFO_DEPTH));
        accept      = imem_req && imem_ready;
        resp        = imem_rvalid && (outstanding_q != '0);
        out_after   = outstanding_q + CW'(accept) - CW'(resp);
        fetch_pc_d  = accept ? fetch_pc_q + 64'd4 : fetch_pc_q;
        resp_pc_d   = resp_pc_q;
        drop_d      = drop_q;
        fifo_push   = 1'b0;
        fifo_wdata  = '{pc: resp_pc_q, inst: imem_rdata};
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            drop_d     = out_after;
        end else if (resp) begin
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end else begin
                fifo_push = 1'b1;
                resp_pc_d = resp_pc_q + 64'd4;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            if_regs_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= out_after;
            drop_q        <= drop_d;
            case (state_q)
                BOOT:    state_q <= FETCH;
                FETCH:   if (redirect && out_after != '0) state_q <= DRAIN;
                DRAIN:   if (drop_d == '0) state_q <= FETCH;
                default: state_q <= BOOT;
            endcase
            if (redirect) begin
                if_regs_q <= '0;
            end else if (!stall) begin
                if_regs_q <= fifo_pop ? '{inst: fifo_head.inst, pc: fifo_head.pc,
                                          pc4: fifo_head.pc + 64'd4} : '0;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FETCH_ENTRY_W)
    ) u_fetch_fifo (
        .clock_i  (clock),
        .reset_ni (reset),
        .push_i   (fifo_push),
        .pop_i    (fifo_pop),
        .clear_i  (redirect),
        .wdata_i  (fifo_wdata),
        .rdata_o  (fifo_head),
        .count_o  (fifo_count),
        .empty_o  (fifo_empty)
    );

    assign imem_addr = fetch_pc_q;
    assign IF_regs   = if_regs_q;
    assign state_dbg = state_q;

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] fetch_cnt_q, squash_cnt_q;
    logic [32:0] squash_sum;
    logic        dropped;

    always_comb begin
        dropped    = resp && (redirect || drop_q != '0);
        squash_sum = {1'b0, squash_cnt_q} + 33'(dropped) + (redirect ? 33'(fifo_count) : 33'd0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            if (fifo_pop && fetch_cnt_q != '1) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            squash_cnt_q <= squash_sum[32] ? '1 : squash_sum[31:0];
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign squash_count = squash_cnt_q;
`endif

    // The credit rule makes a response with nothing outstanding a memory protocol error.
    resp_without_request_a: assert property (@(posedge clock) disable iff (!reset)
        !(imem_rvalid && outstanding_q == '0));

endmodule

// File: tb/tb_core_if.sv
// Self-checking bench for core_if: in-order memory model with tagged epochs and a pc scoreboard.
module tb_core_if;
    import structures::*;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam int          DEPTH   = 2;

    typedef struct {
        logic [63:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        stall, redirect, imem_ready, imem_rvalid, imem_req;
    logic [63:0] redirect_pc, imem_addr;
    logic [31:0] imem_rdata;
    IF_regs_t    if_regs;
    fetch_state_t state_dbg;
    logic        w_req, w_rvalid;
    logic [63:0] w_addr;
    logic [31:0] w_rdata;
    IF_regs_t    w_regs;
    fetch_state_t w_state;
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] fetch_count, squash_count, w_fetch_count, w_squash_count;
`endif

    mreq_t       mem_q[$];
    logic [63:0] exp_q[$];
    IF_regs_t    exp_regs;
    logic [63:0] exp_fetch_pc, last_pc, first_pc, rpc;
    logic        last_req, last_load, got_first, w_acc_prev, st, rd;
    logic [63:0] w_addr_prev;
    int          cyc, epoch, last_due, lat_min, lat_max, ready_pct, max_out, loads, w_loads;
    int          errors, checks, n, l0;

    always #5 clock = ~clock;

    core_if #(.RESET_PC(64'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_regs(if_regs),
`ifdef IF_PERF_COUNTERS_EN
        .fetch_count(fetch_count), .squash_count(squash_count),
`endif
        .state_dbg(state_dbg)
    );

    core_if #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_w (
        .clock(clock), .reset(rst_n), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(64'h0), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(1'b1), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .IF_regs(w_regs),
`ifdef IF_PERF_COUNTERS_EN
        .fetch_count(w_fetch_count), .squash_count(w_squash_count),
`endif
        .state_dbg(w_state)
    );

    function automatic logic [31:0] word(input logic [63:0] a);
        return {a[31:2], 2'b01} ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs at negedge, model the handshake, check IF_regs after posedge.
    task automatic step(input logic s, input logic r, input logic [63:0] rp);
        logic        resp_now;
        mreq_t       m;
        int          lat, due;
        logic [63:0] pc;
        @(negedge clock);
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        imem_ready  = ($urandom_range(100, 1) <= ready_pct);
        resp_now    = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rvalid = resp_now;
        imem_rdata  = resp_now ? word(mem_q[0].addr) : $urandom;
        w_rvalid    = w_acc_prev;
        w_rdata     = word(w_addr_prev);
        #1;
        last_req = imem_req;
        if (imem_req && imem_ready) begin
            check("imem_addr", imem_addr, exp_fetch_pc);
            lat = int'($urandom_range(lat_max, lat_min));
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mem_q.push_back('{addr: exp_fetch_pc, due: due, epoch: epoch});
            last_due = due;
            exp_fetch_pc += 64'd4;
        end
        w_acc_prev  = w_req;
        w_addr_prev = w_addr;
        last_load   = 1'b0;
        if (r) begin
            exp_regs = '0;
            exp_q.delete();
            epoch++;
            exp_fetch_pc = rp;
        end else if (!s) begin
            if (exp_q.size() > 0) begin
                pc        = exp_q.pop_front();
                exp_regs  = '{inst: word(pc), pc: pc, pc4: pc + 64'd4};
                loads++;
                last_load = 1'b1;
                last_pc   = pc;
            end else begin
                exp_regs = '0;
            end
        end
        if (resp_now) begin
            m = mem_q.pop_front();
            if (m.epoch == epoch) exp_q.push_back(m.addr);
        end
        if (mem_q.size() > max_out) max_out = mem_q.size();
        @(posedge clock);
        #1;
        check("if_inst", 64'(if_regs.inst), 64'(exp_regs.inst));
        check("if_pc", if_regs.pc, exp_regs.pc);
        check("if_pc4", if_regs.pc4, exp_regs.pc4);
        if (w_regs.inst != 32'h0) begin
            if (w_loads < 4) begin
                check("wrap_pc", w_regs.pc, WRAP_PC + 64'(4 * w_loads));
                check("wrap_pc4", w_regs.pc4, WRAP_PC + 64'(4 * w_loads + 4));
                check("wrap_inst", 64'(w_regs.inst), 64'(word(WRAP_PC + 64'(4 * w_loads))));
            end
            w_loads++;
        end
        cyc++;
    endtask

    task automatic run_find_first(input int steps);
        got_first = 1'b0;
        first_pc  = '1;
        for (int i = 0; i < steps; i++) begin
            step(1'b0, 1'b0, 64'h0);
            if (last_load && !got_first) begin
                got_first = 1'b1;
                first_pc  = last_pc;
            end
        end
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; epoch = 0; last_due = -1;
        lat_min = 1; lat_max = 1; ready_pct = 100; max_out = 0; loads = 0; w_loads = 0;
        exp_regs = '0; exp_fetch_pc = 64'h0; last_pc = '0; first_pc = '0; got_first = 1'b0;
        w_acc_prev = 1'b0; w_addr_prev = '0; last_req = 1'b0; last_load = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; w_rvalid = 1'b0; w_rdata = '0;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_addr", imem_addr, 64'h0);
        check("rst_regs_pc", if_regs.pc, 64'h0);
        check("rst_regs_inst", 64'(if_regs.inst), 64'h0);
        check("rst_state", 64'(state_dbg), 64'(BOOT));
        check("rst_wrap_addr", w_addr, WRAP_PC);
        check("rst_wrap_state", 64'(w_state), 64'(BOOT));
        @(posedge clock);
        #2;
        rst_n = 1'b1;

        // Sequential fetch with a 1-cycle memory
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 64'h0);
            if (i == 0) check("boot_no_req", 64'(last_req), 64'd0);
            if (i == 1) check("first_req", 64'(last_req), 64'd1);
            if (i == 2) check("no_load_before_c3", 64'(loads), 64'd0);
            if (i == 3) check("first_load_c3", 64'(loads), 64'd1);
        end
        check("sustained_rate", 64'(loads), 64'd27);

        // Stall with the buffer full
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 64'h0);
            if (i > 0) check("stall_no_req", 64'(last_req), 64'd0);
        end
        l0 = loads;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 64'h0);
        check("resume_rate", 64'(loads - l0), 64'd10);

        // Redirect with two outstanding requests
        lat_min = 3; lat_max = 3;
        n = 0;
        while (mem_q.size() != 2 && n < 20) begin
            step(1'b0, 1'b0, 64'h0);
            n++;
        end
        check("two_outstanding", 64'(mem_q.size()), 64'd2);
        step(1'b0, 1'b1, 64'h400);
        check("drain_state", 64'(state_dbg), 64'(DRAIN));
        lat_min = 1; lat_max = 1;
        n = 0;
        while (state_dbg == DRAIN && n < 10) begin
            step(1'b0, 1'b0, 64'h0);
            check("drain_no_req", 64'(last_req), 64'd0);
            n++;
        end
        check("drain_exit", 64'(state_dbg), 64'(FETCH));
        run_find_first(10);
        check("redir_first_pc", first_pc, 64'h400);

        // Redirect coincident with a response and a stall
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 64'h0);
        check("coinc_pending", 64'(mem_q.size()), 64'd1);
        step(1'b1, 1'b1, 64'h800);
        check("coinc_regs_zero", 64'(if_regs.inst), 64'h0);
        run_find_first(10);
        check("coinc_first_pc", first_pc, 64'h800);

        // Random ready, 1-4 cycle latency, occasional stall/redirect
        ready_pct = 70; lat_min = 1; lat_max = 4; max_out = 0;
        l0 = loads;
        n = 0;
        while (loads - l0 < 1000 && n < 20000) begin
            st  = ($urandom_range(100, 1) <= 10);
            rd  = ($urandom_range(1000, 1) <= 5);
            rpc = {32'h0, $urandom};
            rpc[1:0] = 2'b00;
            step(st, rd, rpc);
            n++;
        end
        check("rand_1000_loads", 64'(loads - l0 >= 1000), 64'd1);
        check("max_outstanding", 64'(max_out <= DEPTH), 64'd1);
        check("wrap_seen", 64'(w_loads >= 4), 64'd1);
`ifdef IF_PERF_COUNTERS_EN
        check("fetch_count", 64'(fetch_count), 64'(loads));
        check("wrap_fetch_count", 64'(w_fetch_count), 64'(w_loads));
        check("wrap_squash_count", 64'(w_squash_count), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
